alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one combinational ALU instance between two requesters, for example an integer execute path and an address/branch helper.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block drives the shared ALU's A, B and ALUControl inputs and registers the ALU Result/Zero into a one-entry response buffer tagged with the owning requester.
- Peak throughput: one operation per cycle.

Parameters:
- DATA_W, 32, operand and result width.
- CTRL_W, 4, ALU control code width; codes are passed through unmodified.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  DATA_W  requester 0 operands.
- req0_ctrl  in  CTRL_W  requester 0 ALU control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl: same as requester 0, for requester 1.
- rsp0_valid  out  1  result held for requester 0.
- rsp0_ready  in  1  requester 0 takes its result.
- rsp1_valid  out  1  result held for requester 1.
- rsp1_ready  in  1  requester 1 takes its result.
- rsp_result  out  DATA_W  registered ALU result, shared by both response channels.
- rsp_zero  out  1  registered ALU zero flag.
- alu_a, alu_b  out  DATA_W  operands to the shared ALU.
- alu_ctrl  out  CTRL_W  control code to the shared ALU.
- alu_result  in  DATA_W  ALU result, combinational from alu_a/alu_b/alu_ctrl.
- alu_zero  in  1  ALU zero flag.
- busy  out  1  response buffer occupied.

Behaviour:
- State machine:
  - States: IDLE (buffer empty) and HOLD (buffer full, owner bit valid).
  - rsp_hs = HOLD && rspN_valid && rspN_ready, where N is the owner.
  - can_accept = IDLE || rsp_hs.
- Grant:
  - If exactly one reqN_valid, grant N.
  - If both valid, grant the requester not granted last (pointer last_grant).
  - reqN_ready = can_accept && grant==N. This is combinational and may depend on rspN_ready the same cycle.
  - At most one ready per cycle. Ready is never asserted for a requester whose valid is low.
- Accept cycle (reqN_valid && reqN_ready):
  - alu_a/alu_b/alu_ctrl = requester N's fields, combinationally in the same cycle.
  - On the clock edge: rsp_result <= alu_result; rsp_zero <= alu_zero; owner <= N; last_grant <= N; state <= HOLD.
  - Latency: the result is visible on rspN_valid exactly 1 cycle after the accept edge.
- No accept in a cycle: alu_a = alu_b = 0, alu_ctrl = 0.
- HOLD:
  - rsp{owner}_valid = 1; the other response valid = 0.
  - rsp_result and rsp_zero are stable until the response handshake.
  - Handshake with no new accept -> IDLE.
  - Handshake with a simultaneous accept -> stay in HOLD with the new owner and data (back-to-back).
  - No handshake -> hold everything; both req ready = 0.
- The non-owner's rsp_ready is ignored.
- busy = (state == HOLD).
- Requester contract: a requester must keep its fields stable while valid && !ready. The arbiter samples only on the accept cycle.
- Reset values (applied at the next rising edge while reset = 1):
  - state = IDLE, owner = 0, last_grant = 1 (so requester 0 wins the first tie).
  - rsp_result = 0, rsp_zero = 0.
  - rsp0_valid = rsp1_valid = 0, busy = 0.
  - req0_ready = req1_ready = 0 while reset is high.
  - ALU drive outputs = 0 while reset is high.
- Reset mid-operation: a held result is discarded and never presented. A request presented during reset is not accepted.
- Fairness: with both requesters continuously valid and responses continuously taken, grants alternate 0,1,0,1. Neither requester waits more than one grant.

Test Plan:
1. After reset, req0 only: A=5, B=3, ctrl=0010 -> req0_ready=1 that cycle with alu_a=5; next cycle rsp0_valid=1, rsp_result=8, rsp_zero=0, rsp1_valid=0.
2. Tie after reset: req0 SUB 7-7 (ctrl=0110) and req1 OR 0xF0|0x0F (ctrl=0001), rsp ready high -> req0 is granted first and gets result 0 with zero=1. req1 is granted the next cycle and gets 0x000000FF with zero=0.
3. Backpressure: hold rsp0_ready=0 for 3 cycles with req1 valid -> rsp_result and rsp_zero stable, req1_ready=0, alu_ctrl=0, busy=1. Raise rsp0_ready -> req1 is accepted in that same cycle.
4. Both requesters continuously valid, rsp ready held high for 6 cycles -> grants alternate 0,1,0,1,0,1, busy stays 1, one response per cycle with the correct owner.
5. Assert reset for 1 cycle while HOLD with owner=1 -> rsp1_valid=0 and busy=0 after the edge. A subsequent tie grants requester 0.
6. req1 alone valid for 4 consecutive operations (SLTU 1<2, ctrl=1000) with ready high -> accepted every cycle, each result=1; requester 0 being idle causes no bubble.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready
// requesters, with a one-entry response buffer tagged by the owning requester.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t            state_p1;
  state_t            state_nx;
  logic              owner_p1;
  logic              last_grant_p1;
  logic [DATA_W-1:0] result_p1;
  logic              zero_p1;

  logic              rsp_hs;
  logic              can_accept;
  logic              grant;
  logic              accept;

  // Stage 0: arbitration and ALU drive, all combinational in the accept cycle
  always_comb begin
    state_nx   = state_p1;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = '0;

    rsp_hs     = (state_p1 == HOLD) && (owner_p1 ? rsp1_ready : rsp0_ready);
    can_accept = !reset && ((state_p1 == IDLE) || rsp_hs);

    // On a tie the requester not served last wins; otherwise the lone valid one.
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_p1;
    end else begin
      grant = req1_valid;
    end

    req0_ready = can_accept && req0_valid && !grant;
    req1_ready = can_accept && req1_valid && grant;
    accept     = req0_ready || req1_ready;

    if (req0_ready) begin
      alu_a    = req0_a;
      alu_b    = req0_b;
      alu_ctrl = req0_ctrl;
    end else if (req1_ready) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_ctrl = req1_ctrl;
    end

    if (accept) begin
      state_nx = HOLD;
    end else if (rsp_hs) begin
      state_nx = IDLE;
    end
  end

  // Stage 1: response buffer, owner tag and fairness pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1      <= IDLE;
      owner_p1      <= 1'b0;
      last_grant_p1 <= 1'b1;
      result_p1     <= '0;
      zero_p1       <= 1'b0;
    end else begin
      state_p1 <= state_nx;
      if (accept) begin
        owner_p1      <= grant;
        last_grant_p1 <= grant;
        result_p1     <= alu_result;
        zero_p1       <= alu_zero;
      end
    end
  end

  assign rsp0_valid = (state_p1 == HOLD) && !owner_p1;
  assign rsp1_valid = (state_p1 == HOLD) && owner_p1;
  assign rsp_result = result_p1;
  assign rsp_zero   = zero_p1;
  assign busy       = (state_p1 == HOLD);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU drives the shared ALU port,
// a transaction-level model is checked every cycle, plus directed literal checks.
module tb_alu_share_arbiter;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;

  logic              clk;
  logic              reset;
  logic              req0_valid, req0_ready;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic [CTRL_W-1:0] req0_ctrl;
  logic              req1_valid, req1_ready;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic [CTRL_W-1:0] req1_ctrl;
  logic              rsp0_valid, rsp0_ready;
  logic              rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              busy;

  int total = 0;
  int bad   = 0;

  alu_share_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [CTRL_W-1:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return (a < b) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_result == '0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the buffer as seen by the requesters: one pending response or none.
  logic              m_init  = 1'b0;
  logic              m_full  = 1'b0;
  logic              m_owner = 1'b0;
  logic              m_last  = 1'b1;
  logic [DATA_W-1:0] m_result = '0;
  logic              m_zero  = 1'b0;

  always @(negedge clk) begin
    logic              hs, can, g, er0, er1;
    logic [DATA_W-1:0] ea, eb, res;
    logic [CTRL_W-1:0] ec;
    hs  = m_full && (m_owner ? rsp1_ready : rsp0_ready);
    can = !reset && (!m_full || hs);
    g   = (req0_valid && req1_valid) ? !m_last : req1_valid;
    er0 = can && req0_valid && !g;
    er1 = can && req1_valid && g;
    ea  = er0 ? req0_a    : (er1 ? req1_a    : '0);
    eb  = er0 ? req0_b    : (er1 ? req1_b    : '0);
    ec  = er0 ? req0_ctrl : (er1 ? req1_ctrl : '0);
    chk("m_req0_ready", 32'(req0_ready), 32'(er0));
    chk("m_req1_ready", 32'(req1_ready), 32'(er1));
    chk("m_alu_a", alu_a, ea);
    chk("m_alu_b", alu_b, eb);
    chk("m_alu_ctrl", 32'(alu_ctrl), 32'(ec));
    if (m_init) begin
      chk("m_rsp0_valid", 32'(rsp0_valid), 32'(m_full && !m_owner));
      chk("m_rsp1_valid", 32'(rsp1_valid), 32'(m_full && m_owner));
      chk("m_busy", 32'(busy), 32'(m_full));
      chk("m_rsp_result", rsp_result, m_result);
      chk("m_rsp_zero", 32'(rsp_zero), 32'(m_zero));
    end
    if (reset) begin
      m_init = 1'b1; m_full = 1'b0; m_owner = 1'b0; m_last = 1'b1;
      m_result = '0; m_zero = 1'b0;
    end else if (er0 || er1) begin
      res      = er0 ? alu_f(req0_a, req0_b, req0_ctrl) : alu_f(req1_a, req1_b, req1_ctrl);
      m_full   = 1'b1;
      m_owner  = er1;
      m_last   = er1;
      m_result = res;
      m_zero   = (res == '0);
    end else if (hs) begin
      m_full = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c;
  endtask

  initial begin
    reset = 1'b1;
    set0(1'b0, 0, 0, 4'b0000);
    set1(1'b0, 0, 0, 4'b0000);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // Single request from requester 0
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    set0(1'b1, 5, 3, 4'b0010);
    #1;
    chk("t1_req0_ready", 32'(req0_ready), 1);
    chk("t1_alu_a", alu_a, 5);
    step();
    req0_valid = 1'b0;
    #1;
    chk("t1_rsp0_valid", 32'(rsp0_valid), 1);
    chk("t1_result", rsp_result, 8);
    chk("t1_zero", 32'(rsp_zero), 0);
    chk("t1_rsp1_valid", 32'(rsp1_valid), 0);
    step();

    // Tie straight after reset: requester 0 first
    reset = 1'b1;
    step();
    reset = 1'b0;
    set0(1'b1, 7, 7, 4'b0110);
    set1(1'b1, 32'hF0, 32'h0F, 4'b0001);
    #1;
    chk("t2_req0_ready", 32'(req0_ready), 1);
    chk("t2_req1_ready", 32'(req1_ready), 0);
    step();
    req0_valid = 1'b0;
    #1;
    chk("t2_rsp0_valid", 32'(rsp0_valid), 1);
    chk("t2_result0", rsp_result, 0);
    chk("t2_zero0", 32'(rsp_zero), 1);
    chk("t2_req1_ready", 32'(req1_ready), 1);
    step();
    req1_valid = 1'b0;
    #1;
    chk("t2_rsp1_valid", 32'(rsp1_valid), 1);
    chk("t2_result1", rsp_result, 32'hFF);
    chk("t2_zero1", 32'(rsp_zero), 0);
    step();

    // Response backpressure blocks the other requester
    rsp0_ready = 1'b0;
    set0(1'b1, 10, 20, 4'b0010);
    #1;
    chk("t3_req0_ready", 32'(req0_ready), 1);
    step();
    req0_valid = 1'b0;
    set1(1'b1, 1, 2, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_hold_result", rsp_result, 30);
      chk("t3_hold_zero", 32'(rsp_zero), 0);
      chk("t3_req1_blocked", 32'(req1_ready), 0);
      chk("t3_alu_ctrl", 32'(alu_ctrl), 0);
      chk("t3_busy", 32'(busy), 1);
      step();
    end
    rsp0_ready = 1'b1;
    #1;
    chk("t3_req1_ready", 32'(req1_ready), 1);
    chk("t3_alu_a", alu_a, 1);
    step();
    req1_valid = 1'b0;
    #1;
    chk("t3_rsp1_valid", 32'(rsp1_valid), 1);
    chk("t3_result1", rsp_result, 3);
    step();

    // Both continuously valid: grants alternate
    set0(1'b1, 1, 100, 4'b0010);
    set1(1'b1, 50, 8, 4'b0110);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t4_req0_ready", 32'(req0_ready), 32'((k % 2) == 0));
      chk("t4_req1_ready", 32'(req1_ready), 32'((k % 2) == 1));
      if (k > 0) begin
        chk("t4_busy", 32'(busy), 1);
        chk("t4_result", rsp_result, ((k % 2) == 1) ? 32'd101 : 32'd42);
      end
      step();
    end

    // Reset while holding requester 1's result
    reset = 1'b1;
    rsp1_ready = 1'b0;
    #1;
    chk("t5_rst_req0_ready", 32'(req0_ready), 0);
    chk("t5_rst_req1_ready", 32'(req1_ready), 0);
    chk("t5_rst_alu_a", alu_a, 0);
    step();
    reset = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk("t5_rsp1_valid", 32'(rsp1_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_req0_ready", 32'(req0_ready), 1);
    chk("t5_req1_ready", 32'(req1_ready), 0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("t5_rsp0_valid", 32'(rsp0_valid), 1);
    chk("t5_result", rsp_result, 101);
    step();

    // Requester 1 alone, back-to-back
    set1(1'b1, 1, 2, 4'b1000);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t6_req1_ready", 32'(req1_ready), 1);
      if (k > 0) begin
        chk("t6_rsp1_valid", 32'(rsp1_valid), 1);
        chk("t6_result", rsp_result, 1);
      end
      step();
    end
    req1_valid = 1'b0;
    #1;
    chk("t6_last_rsp1_valid", 32'(rsp1_valid), 1);
    chk("t6_last_result", rsp_result, 1);
    step();
    step();
    #1;
    chk("t6_idle_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
